// File: rtl/musicbox_recording_player.sv
// musicbox_recording_player: streams a stored recording from SDRAM through a prefetch FIFO to the DAC path.
// Define MUSICBOX_PLAYER_UNDERRUN_CNT_EN to build the saturating underrun counter.
module musicbox_recording_player #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int BASE_ADDR    = 0,
  parameter int SAMPLE_COUNT = 110250,
  parameter int CNT_W        = 19,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clock_50Mhz,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [DATA_W-1:0] audio_out,
  output logic              outputActive,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underrun_count,
  output logic [ADDR_W-1:0] sdram_inputAddress,
  output logic [15:0]       sdram_writeData,
  output logic              sdram_isWriting,
  output logic              sdram_inputValid,
  input  logic [15:0]       sdram_readData,
  input  logic              sdram_outputValid,
  input  logic              sdram_recievedCommand,
  input  logic              sdram_isBusy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]        FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   SC    = CNT_W'(SAMPLE_COUNT);
  localparam logic [CNT_W-1:0]   SC_M1 = CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [ADDR_W-1:0]  BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(BASE_ADDR + SAMPLE_COUNT - 1);
  typedef enum logic [1:0] {IDLE, PREFILL, PLAY, ABORT} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [CNT_W-1:0] fetched, played;
  logic loop_l, pending, req;
  logic go, fetching, accept, push, pop, issue, prefilled, fin;
  assign go        = state == IDLE && start && !stop;
  assign fetching  = state == PREFILL || state == PLAY;
  assign accept    = req && sdram_recievedCommand;
  assign push      = pending && sdram_outputValid && fetching;
  assign pop       = state == PLAY && sample_tick && !stop && count != '0;
  assign fin       = pop && !loop_l && played == SC_M1;
  assign prefilled = count == FULL || (fetched == SC && !req && !pending);
  // the very first read goes out on the start edge itself, so it needs no FIFO/fetch checks
  assign issue = (go && !sdram_isBusy) ||
                 (fetching && !stop && !req && !pending && !sdram_isBusy && count < FULL && (fetched < SC || loop_l));
  assign outputActive       = fetching;
  assign busy               = state != IDLE;
  assign sdram_inputValid   = req;
  assign sdram_writeData    = '0;
  assign sdram_isWriting    = 1'b0;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = go ? PREFILL : IDLE;
      PREFILL: state_nxt = stop ? ABORT : prefilled ? PLAY : PREFILL;
      PLAY:    state_nxt = stop ? ABORT : fin ? IDLE : PLAY;
      default: state_nxt = (!pending || sdram_outputValid) ? IDLE : ABORT;
    endcase
  end
  always_ff @(posedge clock_50Mhz) if (push) mem[wr_ptr] <= DATA_W'(sdram_readData);
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      done               <= 1'b0;
      req                <= 1'b0;
      pending            <= 1'b0;
      loop_l             <= 1'b0;
      sdram_inputAddress <= '0;
      fetched            <= '0;
      played             <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      audio_out          <= '0;
    end else begin
      state   <= state_nxt;
      done    <= fin;
      req     <= issue || (req && !accept && !stop && fetching);
      pending <= accept || (pending && !sdram_outputValid);
      if (go) begin
        sdram_inputAddress <= BASE;
        fetched            <= '0;
        played             <= '0;
        loop_l             <= loop_en;
      end else if (accept) begin
        sdram_inputAddress <= sdram_inputAddress == LAST ? BASE : sdram_inputAddress + 1'b1;
        fetched            <= (loop_l && fetched == SC_M1) ? '0 : fetched + 1'b1;
      end
      if (pop) played <= (loop_l && played == SC_M1) ? '0 : played + 1'b1;
      if (go || state == ABORT) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
      audio_out <= (state == IDLE || state == ABORT) ? '0 : pop ? mem[rd_ptr] : audio_out;
    end
  end
`ifdef MUSICBOX_PLAYER_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) ucnt <= '0;
    else if (go) ucnt <= '0;
    else if (state == PLAY && sample_tick && !stop && count == '0 && ucnt != 16'hFFFF) ucnt <= ucnt + 1'b1;
  end
  assign underrun_count = ucnt;
`else
  assign underrun_count = '0;
`endif
endmodule

// File: tb/tb_musicbox_recording_player.sv
// tb_musicbox_recording_player: directed scoreboard bench with an SDRAM model returning data = address.
module tb_musicbox_recording_player;
  localparam int SC = 20;
  logic clock_50Mhz = 0, reset_n = 0, sample_tick = 0, start = 0, stop = 0, loop_en = 0;
  logic [15:0] audio_out, underrun_count, sdram_writeData;
  logic outputActive, busy, done, sdram_isWriting, sdram_inputValid;
  logic [24:0] sdram_inputAddress;
  logic [15:0] sdram_readData = 0;
  logic sdram_outputValid = 0, sdram_recievedCommand = 0, sdram_isBusy = 0;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  int lat = 3, cd = 0, accepts = 0, returns = 0, done_cnt = 0;
  logic hold_cmd = 0, wrap_seen = 0;
  logic [24:0] raddr = 0, last_acc = 0;

  always #10 clock_50Mhz = ~clock_50Mhz;

  musicbox_recording_player #(.SAMPLE_COUNT(SC), .CNT_W(8), .FIFO_DEPTH(8)) dut (
    .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .sample_tick(sample_tick), .start(start),
    .stop(stop), .loop_en(loop_en), .audio_out(audio_out), .outputActive(outputActive),
    .busy(busy), .done(done), .underrun_count(underrun_count),
    .sdram_inputAddress(sdram_inputAddress), .sdram_writeData(sdram_writeData),
    .sdram_isWriting(sdram_isWriting), .sdram_inputValid(sdram_inputValid),
    .sdram_readData(sdram_readData), .sdram_outputValid(sdram_outputValid),
    .sdram_recievedCommand(sdram_recievedCommand), .sdram_isBusy(sdram_isBusy));

  // SDRAM model: accepts a visible request at once unless held, answers after lat cycles
  always @(negedge clock_50Mhz) begin
    sdram_outputValid = 0;
    sdram_recievedCommand = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        sdram_outputValid = 1;
        sdram_readData = raddr[15:0];
        returns++;
      end
    end
    if (sdram_inputValid && !hold_cmd) begin
      sdram_recievedCommand = 1;
      raddr = sdram_inputAddress;
      cd = lat;
      accepts++;
      if (sdram_inputAddress == 0 && last_acc == SC - 1) wrap_seen = 1;
      last_acc = sdram_inputAddress;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock_50Mhz);
      #1;
    end
  endtask

  task automatic do_tick(input logic [15:0] e);
    exp_q.push_back(e);
    sample_tick = 1;
    step(1);
    sample_tick = 0;
    chk("audio", {16'h0, audio_out}, {16'h0, exp_q.pop_front()});
  endtask

  task automatic pulse_start(input logic le);
    loop_en = le;
    start = 1;
    step(1);
    start = 0;
    loop_en = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      step(1);
      n++;
    end
    chk(tag, {31'h0, busy}, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_audio"}, {16'h0, audio_out}, 0);
    chk({tag, "_active"}, {31'h0, outputActive}, 0);
    chk({tag, "_busy"}, {31'h0, busy}, 0);
    chk({tag, "_done"}, {31'h0, done}, 0);
    chk({tag, "_underrun"}, {16'h0, underrun_count}, 0);
    chk({tag, "_addr"}, {7'h0, sdram_inputAddress}, 0);
    chk({tag, "_valid"}, {31'h0, sdram_inputValid}, 0);
    chk({tag, "_wdata"}, {16'h0, sdram_writeData}, 0);
    chk({tag, "_iswr"}, {31'h0, sdram_isWriting}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int popped, und, rbase, abase, n;
    logic [15:0] prev, e;
    logic avail;
    step(3);
    chk_reset_vals("rst");
    reset_n = 1;
    step(2);
    // plain playback of 20 samples
    pulse_start(0);
    chk("first_valid", {31'h0, sdram_inputValid}, 1);
    chk("first_addr", {7'h0, sdram_inputAddress}, 0);
    chk("busy_start", {31'h0, busy}, 1);
    chk("active_start", {31'h0, outputActive}, 1);
    step(100);
    for (int i = 0; i < SC; i++) begin
      step(99);
      do_tick(16'(i));
    end
    chk("done_final", {31'h0, done}, 1);
    chk("busy_final", {31'h0, busy}, 0);
    step(1);
    chk("audio_zero_after", {16'h0, audio_out}, 0);
    chk("done_one_cycle", {31'h0, done}, 0);
    chk("done_count", done_cnt, 1);
    // loop mode wraps past the last sample
    pulse_start(1);
    step(100);
    for (int i = 0; i < SC + 6; i++) begin
      step(99);
      do_tick(16'(i % SC));
    end
    chk("addr_wrap", {31'h0, wrap_seen}, 1);
    chk("loop_busy", {31'h0, busy}, 1);
    chk("loop_no_done", done_cnt, 1);
    stop = 1;
    step(1);
    stop = 0;
    wait_idle("loop_abort_idle");
    chk("loop_abort_audio", {16'h0, audio_out}, 0);
    // underrun: slow SDRAM after the prefill
    rbase = returns;
    pulse_start(0);
    step(100);
    lat = 300;
    popped = 0;
    und = 0;
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      step(99);
      avail = (returns - rbase - (sdram_outputValid ? 1 : 0)) > popped;
      if (avail) begin
        e = 16'(popped);
        popped++;
      end else begin
        e = prev;
        und++;
      end
      prev = e;
      do_tick(e);
    end
`ifdef MUSICBOX_PLAYER_UNDERRUN_CNT_EN
    chk("underrun_count", {16'h0, underrun_count}, und);
`else
    chk("underrun_count", {16'h0, underrun_count}, 0);
`endif
    // stop with an accepted read still in flight
    n = 0;
    while (cd == 0 && n < 400) begin
      step(1);
      n++;
    end
    chk("inflight_found", {31'h0, cd > 0}, 1);
    stop = 1;
    step(1);
    stop = 0;
    chk("abort_busy", {31'h0, busy}, 1);
    chk("abort_active", {31'h0, outputActive}, 0);
    wait_idle("abort_idle");
    chk("abort_waited_resp", cd, 0);
    chk("abort_audio", {16'h0, audio_out}, 0);
    chk("abort_no_done", done_cnt, 1);
    // held command acceptance, then restart from BASE_ADDR
    lat = 3;
    hold_cmd = 1;
    abase = accepts;
    pulse_start(0);
`ifdef MUSICBOX_PLAYER_UNDERRUN_CNT_EN
    chk("underrun_cleared", {16'h0, underrun_count}, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'h0, sdram_inputValid}, 1);
      chk("hold_addr", {7'h0, sdram_inputAddress}, 0);
      step(1);
    end
    chk("hold_no_accept", accepts - abase, 0);
    hold_cmd = 0;
    step(1);
    chk("hold_one_accept", accepts - abase, 1);
    step(100);
    for (int i = 0; i < 3; i++) begin
      step(99);
      do_tick(16'(i));
    end
    // asynchronous reset mid-play
    #3;
    reset_n = 0;
    #1;
    chk_reset_vals("async_rst");
    step(3);
    reset_n = 1;
    step(2);
    start = 1;
    stop = 1;
    step(1);
    start = 0;
    stop = 0;
    chk("startstop_busy", {31'h0, busy}, 0);
    chk("startstop_valid", {31'h0, sdram_inputValid}, 0);
    step(5);
    chk("startstop_busy_later", {31'h0, busy}, 0);
    chk("startstop_active", {31'h0, outputActive}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
